demux_16_bank: RTL
==================

Name: demux_16_bank

Overview:
- Write-side counterpart of the 16:1 read select.
- Accepts a stream of 32-bit words, each tagged with a 4-bit destination index, and latches each word into one of 16 held output registers.
- Supports single writes and auto-incrementing bursts, and raises a per-register update strobe.
- Sits between the processor's memory-mapped output path and the 16 light/sensor-control channels.

Parameters:
- WIDTH, 32, data width of each channel register.
- NREG, 16, number of channels; fixed at 16 since the index is 4 bits; not to be overridden.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to write.
- in_addr  input  4  destination index; sampled only on the first word of a transfer.
- in_burst  input  1  when set with the first word, a burst begins.
- in_len  input  4  number of additional words after the first in a burst (0..15).
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word this cycle.
- clear  input  1  one-cycle request to zero all channels.
- out_flat  output  16*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_strobe  output  16  bit i pulses high for exactly one cycle when channel i changes by write or clear.
- busy  output  1  high while in BURST.

Behaviour:
- Accept: a word transfers on a rising edge where in_valid && in_ready.
- Reset, checked at clock edge: all channels 0, out_strobe 0, state IDLE, pointer 0, count 0, busy 0.
- in_ready is combinational: equals !clear && !reset, in both states.
- States:
  - IDLE: on accept with in_burst=0, write reg[in_addr]; stay IDLE.
  - IDLE: on accept with in_burst=1 and in_len=0, behave as a single write; stay IDLE.
  - IDLE: on accept with in_burst=1 and in_len>0, write reg[in_addr], set ptr=in_addr+1 (mod 16) and count=in_len, go to BURST.
  - BURST: each accept writes reg[ptr], increments ptr mod 16 (wraps 15->0), and decrements count. The accept that takes count from 1 to 0 returns to IDLE.
  - BURST: in_addr, in_burst and in_len are ignored.
- Stalls: no accept (in_valid low) leaves state, ptr and count unchanged. Bursts tolerate arbitrary gaps.
- Wrap: a burst longer than the channels remaining to index 15 wraps to 0. A burst of 16 words starting at k overwrites all 16 channels; the last word lands in k-1.
- Latency: an accepted word is visible on out_flat the cycle after the accepting edge. out_strobe bit for that channel is high in that same cycle only.
- Back-to-back accepts: strobes for consecutive channels appear on consecutive cycles. A channel written twice in a row holds its strobe high for two cycles, once per write.
- Clear: on the edge where clear=1, all channels go to 0 and all 16 strobe bits assert next cycle. State returns to IDLE and count to 0, aborting any burst. No word is accepted, because in_ready is low.
- Reset mid-burst: returns to reset state; partially written channels are zeroed.
- Reset has priority over clear; clear has priority over writes.
- busy = (state == BURST), registered.

Optional Feature:
- Macro: DEMUX_16_WRITE_MASK_EN.
- When defined, adds input write_mask [15:0]. A word accepted for channel i with write_mask[i]=1 is consumed, so ptr and count advance normally, but reg[i] is unchanged and strobe bit i is not asserted. Clear ignores the mask.
- When undefined, the port does not exist and every channel is writable.

Test Plan:
- Reset, then single write in_addr=5, data 0xDEADBEEF -> next cycle channel 5 = 0xDEADBEEF, out_strobe=0x0020 for one cycle, all other channels 0.
- Burst in_addr=14, in_len=3, words 1,2,3,4 with a 2-cycle valid gap after word 2 -> ch14=1, ch15=2, ch0=3, ch1=4. busy falls after the 4th accept; strobes follow 0x4000, 0x8000, 0x0001, 0x0002.
- clear asserted mid-burst after 2 of 6 words -> in_ready=0 that cycle, all channels 0, out_strobe=0xFFFF next cycle, busy=0. The next word is treated as a new IDLE transfer using its in_addr.
- reset asserted with in_valid=1 during BURST -> no write; all outputs 0 the following cycle, state IDLE.
- 16-word burst from index 7 with distinct data -> every channel written; ch6 holds the final word.
- With DEMUX_16_WRITE_MASK_EN and write_mask=0x0004: burst from 1, in_len=2, words A,B,C -> ch1=A, ch2 unchanged, ch3=C; strobe bit 2 never asserts.

Source files
------------

// File: rtl/demux_16_bank.sv
// 16-channel write demux: latches tagged words into held channel registers, with bursts and update strobes.
// Optional per-channel write masking is enabled by defining DEMUX_16_WRITE_MASK_EN.

// state   | meaning
// S_IDLE  | waiting for the first word of a transfer; in_addr/in_burst/in_len are sampled
// S_BURST | burst in progress; words go to r_ptr until r_count reaches zero
module demux_16_bank #(
    parameter int WIDTH = 32,
    parameter int NREG  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [3:0]              in_addr,
    input  logic                    in_burst,
    input  logic [3:0]              in_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    clear,
`ifdef DEMUX_16_WRITE_MASK_EN
    input  logic [NREG-1:0]         write_mask,
`endif
    output logic [NREG*WIDTH-1:0]   out_flat,
    output logic [NREG-1:0]         out_strobe,
    output logic                    busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_ptr;
    logic [3:0]        r_count;
    logic [WIDTH-1:0]  r_chan [NREG];
    logic [NREG-1:0]   r_strobe;
    logic [NREG-1:0]   w_wr_en;
    logic              w_accept;
    logic              w_start_burst;
    logic [3:0]        w_target;

    assign in_ready      = !clear && !reset;
    assign w_accept      = in_valid && in_ready;
    assign w_target      = (r_state == S_IDLE) ? in_addr : r_ptr;
    assign w_start_burst = (r_state == S_IDLE) && w_accept && in_burst && (in_len != 4'd0);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_burst) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_accept && (r_count == 4'd1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr_en = '0;
        if (w_accept) begin
            w_wr_en[w_target] = 1'b1;
        end
`ifdef DEMUX_16_WRITE_MASK_EN
        // masked words are still consumed; only the register update is suppressed
        w_wr_en = w_wr_en & ~write_mask;
`endif
    end

    assign busy = (r_state == S_BURST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_ptr   <= 4'd0;
            r_count <= 4'd0;
        end else if (w_accept) begin
            // 4-bit pointer wraps 15 -> 0 on its own
            r_ptr <= w_target + 4'd1;
            if (w_start_burst) begin
                r_count <= in_len;
            end else if (r_state == S_BURST) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_strobe <= '0;
        end else if (clear) begin
            r_strobe <= '1;
        end else begin
            r_strobe <= w_wr_en;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_chan
        always_ff @(posedge clock) begin
            if (reset || clear) begin
                r_chan[g] <= '0;
            end else if (w_wr_en[g]) begin
                r_chan[g] <= in_data;
            end
        end
        assign out_flat[g*WIDTH +: WIDTH] = r_chan[g];
    end

    assign out_strobe = r_strobe;

endmodule
